pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 106 ++++++++++
 tb/tb_pipe_skid_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with registered ready/valid, flush and a stall counter.
// Optional macro PIPE_STALL_CNT_EN enables the stall counter; otherwise stall_cnt is tied to 0.
module pipe_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] main_q, main_nx;
    logic [DATA_W-1:0] skid_q, skid_nx;
    logic              accept, deliver;

    // Handshake flags come only from registered state, so m_ready never reaches s_ready.
    assign s_ready   = (state != FULL);
    assign m_valid   = (state != EMPTY);
    assign occupancy = state;
    assign m_data    = main_q;

    assign accept  = s_valid && s_ready;
    assign deliver = m_valid && m_ready;

    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = '0;
            skid_nx  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nx = ONE;
                        main_nx  = s_data;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_nx = s_data;
                    end else if (accept) begin
                        state_nx = FULL;
                        skid_nx  = s_data;
                    end else if (deliver) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        state_nx = ONE;
                        main_nx  = skid_q;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of back-pressured cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (m_valid && !m_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: queue-based reference model plus directed scenarios.
module tb_pipe_skid_reg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_skid_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the held entries are a FIFO queue of at most two items.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_last;
    int unsigned       m_cnt;

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
`ifdef PIPE_STALL_CNT_EN
            if (mq.size() != 0 && !m_ready && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
            if (flush) begin
                mq.delete();
                m_last = '0;
            end else begin
                automatic bit acc = s_valid && (mq.size() < 2);
                automatic bit del = (mq.size() != 0) && m_ready;
                if (del) void'(mq.pop_front());
                if (acc) mq.push_back(s_data);
            end
            if (mq.size() != 0) m_last = mq[0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid",   32'(m_valid),   32'(mq.size() != 0));
            chk("s_ready",   32'(s_ready),   32'(mq.size() < 2));
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
            chk("m_data",    32'(m_data),    32'((mq.size() != 0) ? mq[0] : m_last));
            chk("stall_cnt", 32'(stall_cnt), m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef PIPE_STALL_CNT_EN
        return (n > CNT_MAX) ? CNT_MAX : n;
`else
        return 32'(n * 0);
`endif
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        @(negedge clk);

        // Reset values
        rst = 1'b0; s_valid = 1'b1; m_ready = 1'b1; flush = 1'b1; s_data = 8'hEE;
        step();
        chk_en = 1'b1;
        chk("rst_s_ready",   32'(s_ready),   32'd1);
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_occ",       32'(occupancy), 32'd0);
        chk("rst_m_data",    32'(m_data),    32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0;

        // Streaming 1..4 with m_ready high
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_data = DATA_W'(i);
            step();
            chk("stream_data", 32'(m_data),    32'(i));
            chk("stream_occ",  32'(occupancy), 32'd1);
        end
        s_valid = 1'b0;
        step();
        chk("empty_hold_valid", 32'(m_valid), 32'd0);
        chk("empty_hold_data",  32'(m_data),  32'd4);

        // Back-pressure
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h0A;
        step();
        s_data = 8'h0B;
        step();
        s_valid = 1'b0;
        step();
        chk("bp_occ",     32'(occupancy), 32'd2);
        chk("bp_s_ready", 32'(s_ready),   32'd0);
        chk("bp_head",    32'(m_data),    32'h0A);
        m_ready = 1'b1;
        step();
        chk("bp_second", 32'(m_data),    32'h0B);
        chk("bp_occ1",   32'(occupancy), 32'd1);
        step();
        chk("bp_drained", 32'(m_valid),   32'd0);
        chk("bp_stall",   32'(stall_cnt), exp_cnt(2));

        // Flush in FULL with an entry offered
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h01;
        step();
        s_data = 8'h02;
        step();
        flush = 1'b1; s_data = 8'h0C; m_ready = 1'b1;
        step();
        chk("fl_occ",     32'(occupancy), 32'd0);
        chk("fl_m_valid", 32'(m_valid),   32'd0);
        chk("fl_m_data",  32'(m_data),    32'd0);
        chk("fl_s_ready", 32'(s_ready),   32'd1);
        flush = 1'b0; s_valid = 1'b0;
        repeat (3) step();
        chk("fl_no_0C", 32'(m_valid), 32'd0);

        // Simultaneous accept and deliver in ONE
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h05;
        step();
        chk("sim_head", 32'(m_data), 32'h05);
        s_data = 8'h06; m_ready = 1'b1;
        step();
        chk("sim_data", 32'(m_data),    32'h06);
        chk("sim_occ",  32'(occupancy), 32'd1);
        s_valid = 1'b0;
        step();

        // Stall counter saturation
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h07;
        step();
        s_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("sat_stall", 32'(stall_cnt), exp_cnt(i));
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_kept_by_flush", 32'(stall_cnt), exp_cnt(6));

        // Reset while FULL
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h08;
        step();
        s_data = 8'h09;
        step();
        rst = 1'b0; m_ready = 1'b1; s_data = 8'h33;
        step();
        chk("rf_s_ready", 32'(s_ready),   32'd1);
        chk("rf_m_valid", 32'(m_valid),   32'd0);
        chk("rf_occ",     32'(occupancy), 32'd0);
        chk("rf_m_data",  32'(m_data),    32'd0);
        chk("rf_stall",   32'(stall_cnt), 32'd0);
        rst = 1'b1; s_valid = 1'b0;
        repeat (3) step();
        chk("rf_no_delivery", 32'(m_valid), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
